// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined ALU.
// Flag support in alu_core/alu_pipe is enabled by defining ALU_PIPE_FLAGS_EN.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLL = 3'b101,
      OP_SRL = 3'b110,
      OP_SLT = 3'b111
   } alu_op_t;

   localparam int FLAG_Z  = 0;
   localparam int FLAG_C  = 1;
   localparam int FLAG_V  = 2;
   localparam int FLAG_N  = 3;
   localparam int FLAGS_W = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between the operand and result stages.
// Flag outputs exist only when ALU_PIPE_FLAGS_EN is defined.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] y_o
`ifdef ALU_PIPE_FLAGS_EN
   ,
   output logic [FLAGS_W-1:0] flags_o
`endif
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] shamt;

   assign shamt = b_i[SHW-1:0];

   always_comb begin
      y_o = '0;
      case (alu_op_t'(op_i))
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_SLL:  y_o = a_i << shamt;
         OP_SRL:  y_o = a_i >> shamt;
         OP_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: y_o = '0;
      endcase
   end

`ifdef ALU_PIPE_FLAGS_EN
   logic carry;
   logic ovf;

   // Carry-out of an add shows up as the wrapped sum being below an operand.
   always_comb begin
      carry = 1'b0;
      ovf   = 1'b0;
      case (alu_op_t'(op_i))
         OP_ADD: begin
            carry = (y_o < a_i);
            ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            carry = (a_i < b_i);
            ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (y_o[WIDTH-1] != a_i[WIDTH-1]);
         end
         default: begin
            carry = 1'b0;
            ovf   = 1'b0;
         end
      endcase
      flags_o         = '0;
      flags_o[FLAG_N] = y_o[WIDTH-1];
      flags_o[FLAG_V] = ovf;
      flags_o[FLAG_C] = carry;
      flags_o[FLAG_Z] = (y_o == '0);
   end
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds the result.
// Define ALU_PIPE_FLAGS_EN to add the FLAGS {N,V,C,Z} output and its registers.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OP,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y
`ifdef ALU_PIPE_FLAGS_EN
   ,
   output logic [FLAGS_W-1:0] FLAGS
`endif
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] core_y;
   logic             s2_adv;

   // S2 can take a new result when it is empty or being drained this cycle.
   assign s2_adv    = !out_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || s2_adv;
   assign out_valid = out_valid_q;
   assign Y         = y_q;

`ifdef ALU_PIPE_FLAGS_EN
   logic [FLAGS_W-1:0] flags_q, flags_d;
   logic [FLAGS_W-1:0] core_flags;

   assign FLAGS = flags_q;
`endif

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a_i     (a_q),
      .b_i     (b_q),
      .op_i    (op_q),
`ifdef ALU_PIPE_FLAGS_EN
      .flags_o (core_flags),
`endif
      .y_o     (core_y)
   );

   always_comb begin
      s1_valid_d  = s1_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      out_valid_d = out_valid_q;
      y_d         = y_q;
`ifdef ALU_PIPE_FLAGS_EN
      flags_d     = flags_q;
`endif
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            a_d  = A;
            b_d  = B;
            op_d = OP;
         end
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            y_d     = core_y;
`ifdef ALU_PIPE_FLAGS_EN
            flags_d = core_flags;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
`ifdef ALU_PIPE_FLAGS_EN
         flags_q     <= '0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
`ifdef ALU_PIPE_FLAGS_EN
         flags_q     <= flags_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed + scoreboard bench for alu_pipe (WIDTH=8 main instance, WIDTH=16 shift instance).
// Flag checks are active when ALU_PIPE_FLAGS_EN is defined.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, y;
   logic [2:0] op;
   logic [3:0] flags;

   logic        v16, rdy16, ov16, or16;
   logic [15:0] a16, b16, y16;
   logic [2:0]  op16;
   logic [3:0]  flags16;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int acc_cnt = 0;
   int emit_cnt = 0;
   logic [11:0] sb_q[$];

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .OP(op), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ALU_PIPE_FLAGS_EN
      .FLAGS(flags),
`endif
      .Y(y)
   );

   alu_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
      .A(a16), .B(b16), .OP(op16), .out_valid(ov16), .out_ready(or16),
`ifdef ALU_PIPE_FLAGS_EN
      .FLAGS(flags16),
`endif
      .Y(y16)
   );

`ifndef ALU_PIPE_FLAGS_EN
   assign flags   = 4'h0;
   assign flags16 = 4'h0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: returns {N,V,C,Z, Y} using integer arithmetic.
   function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
      int ua, ub, sa, sb, r;
      logic [7:0] ry;
      logic rc, rv;
      ua = int'(ma);
      ub = int'(mb);
      sa = ma[7] ? ua - 256 : ua;
      sb = mb[7] ? ub - 256 : ub;
      rc = 1'b0;
      rv = 1'b0;
      ry = 8'h00;
      case (mop)
         3'd0: begin r = ua + ub; ry = r[7:0]; rc = (r > 255); r = sa + sb; rv = (r > 127) || (r < -128); end
         3'd1: begin r = ua - ub; ry = r[7:0]; rc = (ua < ub); r = sa - sb; rv = (r > 127) || (r < -128); end
         3'd2: ry = ma & mb;
         3'd3: ry = ma | mb;
         3'd4: ry = ma ^ mb;
         3'd5: begin r = ua << (ub % 8); ry = r[7:0]; end
         3'd6: begin r = ua >> (ub % 8); ry = r[7:0]; end
         default: ry = (sa < sb) ? 8'h01 : 8'h00;
      endcase
      return {ry[7], rv, rc, (ry == 8'h00), ry};
   endfunction

   // One clock: record transfers seen this cycle, then advance to just past the edge.
   task automatic cycle();
      logic [11:0] e;
      #1;
      if (in_valid && in_ready) begin
         sb_q.push_back(model(a, b, op));
         acc_cnt = acc_cnt + 1;
      end
      if (out_valid && out_ready) begin
         emit_cnt = emit_cnt + 1;
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            $display("out #%0d: Y=%02h FLAGS=%h exp Y=%02h FLAGS=%h", emit_cnt, y, flags, e[7:0], e[11:8]);
            chk("sb_y", 32'(y), 32'(e[7:0]));
`ifdef ALU_PIPE_FLAGS_EN
            chk("sb_flags", 32'(flags), 32'(e[11:8]));
`endif
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db, input logic [2:0] dop);
      in_valid = v;
      a  = da;
      b  = db;
      op = dop;
   endtask

   initial begin
      logic [6:0]  pat;
      logic        ir_all;
      logic [7:0]  y_first;
      logic [3:0]  f_first;
      int          acc0, emit0;
      logic [7:0]  b2b_a[4] = '{8'h12, 8'hF0, 8'hAA, 8'h81};
      logic [7:0]  b2b_b[4] = '{8'h34, 8'h0F, 8'h55, 8'h09};
      logic [2:0]  b2b_op[4] = '{3'd0, 3'd3, 3'd4, 3'd6};

      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      out_ready = 1'b1;
      v16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; or16 = 1'b1;
      y_first = '0; f_first = '0;

      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_y", 32'(y), 32'd0);
`ifdef ALU_PIPE_FLAGS_EN
      chk("rst_flags", 32'(flags), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // ADD wrap-around, accepted on the first edge after reset release
      drive(1'b1, 8'hFF, 8'h01, 3'd0);
      cycle();
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      chk("add_lat1_out_valid", 32'(out_valid), 32'd0);
      cycle();
      chk("add_lat2_out_valid", 32'(out_valid), 32'd1);
      chk("add_y", 32'(y), 32'h00);
`ifdef ALU_PIPE_FLAGS_EN
      chk("add_flags", 32'(flags), 32'b0011);
`endif
      cycle();

      // SUB signed overflow, then SLT signed compare
      drive(1'b1, 8'h80, 8'h01, 3'd1);
      cycle();
      drive(1'b1, 8'h80, 8'h01, 3'd7);
      cycle();
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      chk("sub_y", 32'(y), 32'h7F);
`ifdef ALU_PIPE_FLAGS_EN
      chk("sub_flags", 32'(flags), 32'b0100);
`endif
      cycle();
      chk("slt_y", 32'(y), 32'h01);
`ifdef ALU_PIPE_FLAGS_EN
      chk("slt_flags", 32'(flags), 32'b0000);
`endif
      cycle();
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // Back-to-back four ops with out_ready held high
      ir_all = 1'b1;
      pat = '0;
      for (int j = 0; j < 7; j++) begin
         if (j < 4) drive(1'b1, b2b_a[j], b2b_b[j], b2b_op[j]);
         else       drive(1'b0, 8'h00, 8'h00, 3'd0);
         #1;
         pat[j] = out_valid;
         ir_all = ir_all & in_ready;
         cycle();
      end
      chk("b2b_valid_pattern", 32'(pat), 32'b0111100);
      chk("b2b_in_ready_high", 32'(ir_all), 32'd1);

      // Downstream stall with continuous input
      out_ready = 1'b0;
      acc0 = acc_cnt;
      for (int j = 0; j < 5; j++) begin
         drive(1'b1, 8'(8'h10 + j), 8'(8'h03 + j), 3'(j));
         if (j == 2) begin
            y_first = y;
            f_first = flags;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
         end else if (j > 2) begin
            chk("stall_y_stable", 32'(y), 32'(y_first));
            chk("stall_flags_stable", 32'(flags), 32'(f_first));
         end
         cycle();
      end
      #1;
      chk("stall_accepted", 32'(acc_cnt - acc0), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      out_ready = 1'b1;
      emit0 = emit_cnt;
      for (int j = 0; j < 8 && sb_q.size() != 0; j++) cycle();
      chk("stall_drain_emitted", 32'(emit_cnt - emit0), 32'd2);
      chk("stall_drain_empty", 32'(sb_q.size()), 32'd0);

      // Reset with two ops in flight
      drive(1'b1, 8'h05, 8'h06, 3'd0);
      cycle();
      drive(1'b1, 8'h07, 8'h08, 3'd2);
      cycle();
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_y", 32'(y), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      emit0 = emit_cnt;
      for (int j = 0; j < 4; j++) cycle();
      chk("post_rst_no_emit", 32'(emit_cnt - emit0), 32'd0);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);

      // WIDTH=16 shift: only the low log2(16) bits of B count
      v16 = 1'b1; a16 = 16'h0001; b16 = 16'h0013; op16 = 3'd5;
      #1;
      chk("w16_in_ready", 32'(rdy16), 32'd1);
      cycle();
      v16 = 1'b0;
      chk("w16_lat1_out_valid", 32'(ov16), 32'd0);
      cycle();
      $display("w16 SLL: Y=%04h out_valid=%0b", y16, ov16);
      chk("w16_out_valid", 32'(ov16), 32'd1);
      chk("w16_sll_y", 32'(y16), 32'h0008);
`ifdef ALU_PIPE_FLAGS_EN
      chk("w16_sll_flags", 32'(flags16), 32'd0);
`endif
      cycle();

      // Random mix with random backpressure, all ops cross-checked by the scoreboard
      for (int j = 0; j < 40; j++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               3'($urandom_range(0, 7)));
         out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      drive(1'b0, 8'h00, 8'h00, 3'd0);
      out_ready = 1'b1;
      for (int j = 0; j < 8 && sb_q.size() != 0; j++) cycle();
      chk("rand_drain_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
